fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the RV32I five-stage pipeline, directly upstream of decode. Owns the PC and drives a single-outstanding request/response instruction-memory port. Holds the IF/ID pipeline register that produces InstrD/PCD/PCPlus4D for decode. Honours branch redirects from execute and load-use stalls from the hazard unit, using a one-entry hold buffer so no fetched instruction is lost.

## Interface
- RESET_PC, 32'h00000000, PC of the first fetch after reset
- NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0) driven on InstrD when no valid instruction
- clk  input  1  pipeline clock, all state on posedge
- rst  input  1  reset, asynchronous, active-high (one clock; async active-high reset is fixed)
- PCSrcE  input  1  branch/jump taken in execute; redirect fetch
- PCTargetE  input  32  redirect target, valid when PCSrcE=1
- stallF_load_hazard  input  1  load-use stall; freeze IF/ID and issue nothing
- imem_req  output  1  request strobe, accepted the cycle it is high
- imem_addr  output  32  fetch address (= PCF)
- imem_rvalid  input  1  response valid; one response per request, ≥1 cycle after request
- imem_rdata  input  32  instruction word, valid with imem_rvalid
- PCF  output  32  next fetch address
- InstrD, PCD, PCPlus4D  output  32 each  IF/ID register to decode
- ValidD  output  1  IF/ID holds a real instruction

## Operation
- States: IDLE (nothing outstanding), WAIT (one request outstanding), DISCARD (outstanding response is stale, drop it).
- Internal: PCF, pc_out (PC of outstanding request), hold_valid/hold_instr/hold_pc.
- issue = !PCSrcE && !stallF_load_hazard && (state==IDLE || imem_rvalid); imem_req = issue (combinational), imem_addr = PCF.
- On issue: pc_out<=PCF, PCF<=PCF+4, state<=WAIT.
- Priority per cycle: redirect > stall > normal.
- Redirect (PCSrcE=1): PCF<=PCTargetE; IF/ID<=bubble; hold_valid<=0; WAIT without rvalid -> DISCARD; WAIT or DISCARD with rvalid -> response dropped, IDLE; IDLE stays IDLE.
- Stall: IF/ID holds. WAIT with rvalid -> hold<={rdata, pc_out}, hold_valid<=1, IDLE. DISCARD with rvalid -> IDLE (dropped).
- Normal: if hold_valid, IF/ID<=hold, hold_valid<=0; else if WAIT && rvalid, IF/ID<={rdata, pc_out, pc_out+4, 1}; else IF/ID<=bubble. DISCARD with rvalid drops data, IF/ID<=bubble. Non-issue with rvalid -> IDLE.
- Bubble: InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
- hold_valid=1 implies state IDLE; hold and live response never coincide.
- imem_rvalid in IDLE: protocol error, ignored.
- Arithmetic 32-bit modulo: PCF 0xFFFFFFFC -> 0x00000000; PCPlus4D wraps identically. PCTargetE taken as-is (no alignment check).

## Timing
- Reset values: PCF=RESET_PC, state IDLE, hold_valid=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0; imem_req low while rst high.
- First cycle with rst low: imem_req=1, imem_addr=RESET_PC.
- 1-cycle memory: req cycle n, rvalid n+1, instruction on InstrD from cycle n+2; sustained one instruction per cycle (re-issue in rvalid cycle).
- Redirect cycle n: no request; request to PCTargetE in n+1 (or when stale response drains); IF/ID bubble from n+1.
- Stall releases: held instruction presented the cycle after release; new request issues in release cycle.
- Reset mid-operation clears all state; instruction memory shares rst, so no stale response survives reset.

## Structure
- Shared package rv32i_pkg: XLEN=32, NOP_INSTR constant, fetch state enum (IDLE/WAIT/DISCARD).
- Single module; no sub-module — PC, FSM, hold buffer and IF/ID register are tightly coupled.

## Test plan
- Reset, 1-cycle memory returning addr-as-data -> InstrD sequence 0x0,0x4,0x8 on consecutive cycles from cycle 2, ValidD=1, PCPlus4D=PCD+4.
- PCSrcE=1 target 0x100 while request to 0x8 outstanding (3-cycle memory) -> 0x8 data never reaches ValidD=1; next ValidD=1 has PCD=0x100.
- stallF_load_hazard high 3 cycles while response for 0x10 arrives -> IF/ID frozen, 0x10 presented the cycle after release, no duplicate or skip.
- Redirect and rvalid same cycle -> response dropped, state IDLE, next request addr=PCTargetE next cycle.
- RESET_PC=0xFFFFFFFC -> first PCPlus4D=0x00000000, second fetch address 0x00000000.
- Assert rst during WAIT -> all outputs return to reset values immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: data width, bubble encoding, fetch FSM states
// and the IF/ID register layout.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FetchIdle,
    FetchWait,
    FetchDiscard
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{
    instr:    NOP_INSTR,
    pc:       '0,
    pc_plus4: '0,
    valid:    1'b0
  };

endpackage

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: owns the PC, drives a single-outstanding imem port and the
// IF/ID register, with a one-entry hold buffer so a response arriving during a stall survives.
module fetch_stage
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            stallF_load_hazard,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic            hold_valid_q, hold_valid_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  ifid_t           ifid_q, ifid_d;

  logic issue;
  logic rsp_live;
  logic rsp_stale;

  // rvalid while IDLE is a protocol error and is deliberately not decoded here.
  assign rsp_live  = (state_q == FetchWait) && imem_rvalid;
  assign rsp_stale = (state_q == FetchDiscard) && imem_rvalid;

  assign issue = !rst && !PCSrcE && !stallF_load_hazard &&
                 ((state_q == FetchIdle) || imem_rvalid);

  assign imem_req  = issue;
  assign imem_addr = pcf_q;
  assign PCF       = pcf_q;

  assign InstrD   = ifid_q.instr;
  assign PCD      = ifid_q.pc;
  assign PCPlus4D = ifid_q.pc_plus4;
  assign ValidD   = ifid_q.valid;

  always_comb begin
    state_d      = state_q;
    pcf_d        = pcf_q;
    pc_out_d     = pc_out_q;
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    ifid_d       = ifid_q;

    if (PCSrcE) begin
      pcf_d        = PCTargetE;
      ifid_d       = IFID_BUBBLE;
      hold_valid_d = 1'b0;
      if (state_q != FetchIdle) begin
        state_d = imem_rvalid ? FetchIdle : FetchDiscard;
      end
    end else if (stallF_load_hazard) begin
      // IF/ID frozen; a live response parks in the hold buffer instead.
      if (rsp_live) begin
        hold_valid_d = 1'b1;
        hold_instr_d = imem_rdata;
        hold_pc_d    = pc_out_q;
        state_d      = FetchIdle;
      end else if (rsp_stale) begin
        state_d = FetchIdle;
      end
    end else begin
      if (hold_valid_q) begin
        ifid_d       = '{instr: hold_instr_q, pc: hold_pc_q,
                         pc_plus4: hold_pc_q + 32'd4, valid: 1'b1};
        hold_valid_d = 1'b0;
      end else if (rsp_live) begin
        ifid_d = '{instr: imem_rdata, pc: pc_out_q,
                   pc_plus4: pc_out_q + 32'd4, valid: 1'b1};
      end else begin
        ifid_d = IFID_BUBBLE;
      end

      if (rsp_live || rsp_stale) begin
        state_d = FetchIdle;
      end

      if (issue) begin
        pc_out_d = pcf_q;
        pcf_d    = pcf_q + 32'd4;
        state_d  = FetchWait;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FetchIdle;
      pcf_q        <= RESET_PC;
      pc_out_q     <= '0;
      hold_valid_q <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      ifid_q       <= IFID_BUBBLE;
    end else begin
      state_q      <= state_d;
      pcf_q        <= pcf_d;
      pc_out_q     <= pc_out_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      ifid_q       <= ifid_d;
    end
  end

endmodule
